// File: rtl/feature_framer.sv
`timescale 1ns/1ps
// feature_framer
// Collects one CHANNEL_WIDTH-bit feature per sensor beat into a full frame and
// hands completed frames to the fusion core over a valid/ready port. An assembly
// register and an output register form a double buffer, so one frame can stream
// in while the previous one waits for the core. Frames that end early or run
// long are discarded and reported with a one-cycle error pulse.
module feature_framer #(
    parameter int NUM_CHANNEL   = 214,
    parameter int CHANNEL_WIDTH = 2,
    parameter int CNT_WIDTH     = $clog2(NUM_CHANNEL)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [CHANNEL_WIDTH-1:0]             s_data,
    input  logic                                 s_last,
    output logic                                 fin_valid,
    input  logic                                 fin_ready,
    output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
    output logic                                 err_short,
    output logic                                 err_long,
    output logic [15:0]                          frame_count
);

    localparam int FRAME_W = NUM_CHANNEL * CHANNEL_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_CHANNEL - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] idx;
    logic [FRAME_W-1:0]   asm_reg;
    logic [FRAME_W-1:0]   asm_next;

    logic beat;
    logic at_last;
    logic out_free;
    logic complete;
    logic load_out;

    // A frame may enter the output register when it is empty or being drained now.
    assign beat     = s_valid && s_ready;
    assign at_last  = (idx == LAST_IDX);
    assign out_free = !fin_valid || fin_ready;
    assign complete = beat && (state == FILL) && at_last && s_last;
    assign load_out = (complete || (state == HOLD)) && out_free;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: completion, overrun into DROP, and parking in HOLD
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (beat && at_last) begin
                    if (!s_last) begin
                        state_next = DROP;
                    end else if (!out_free) begin
                        state_next = HOLD;
                    end
                end
            end
            DROP: begin
                if (beat && s_last) begin
                    state_next = FILL;
                end
            end
            HOLD: begin
                if (out_free) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Output decode: the sensor is stalled only while a finished frame is parked
    always_comb begin
        s_ready = (state != HOLD);
    end

    // Assembly image including the beat being accepted this cycle (channel 0 in the MSBs)
    always_comb begin
        asm_next = asm_reg;
        if ((state == FILL) && beat) begin
            for (int k = 0; k < NUM_CHANNEL; k++) begin
                if (idx == CNT_WIDTH'(k)) begin
                    asm_next[(NUM_CHANNEL - k) * CHANNEL_WIDTH - 1 -: CHANNEL_WIDTH] = s_data;
                end
            end
        end
    end

    // Assembly register and beat index; the index restarts on any frame boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_reg <= '0;
            idx     <= '0;
        end else begin
            asm_reg <= asm_next;
            if (state != FILL) begin
                idx <= '0;
            end else if (beat) begin
                idx <= (s_last || at_last) ? '0 : idx + CNT_WIDTH'(1);
            end
        end
    end

    // Output register: only complete frames enter, and only when it is free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            features_top <= '0;
            fin_valid    <= 1'b0;
        end else if (load_out) begin
            features_top <= asm_next;
            fin_valid    <= 1'b1;
        end else if (fin_valid && fin_ready) begin
            fin_valid    <= 1'b0;
        end
    end

    // Accepted-frame counter and single-cycle drop indicators
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
        end else begin
            if (fin_valid && fin_ready) begin
                frame_count <= frame_count + 16'd1;
            end
            err_short <= beat && (state == FILL) && s_last && !at_last;
            err_long  <= beat && (state == DROP) && s_last;
        end
    end

endmodule

// File: tb/tb_feature_framer.sv
`timescale 1ns/1ps
// tb_feature_framer
// Table of frame shapes plus directed sequences and randomized traffic, all
// checked against a frame-level reference model that classifies each sensor
// frame by its length and predicts the packed image the core should receive.
module tb_feature_framer;

    localparam int N  = 214;
    localparam int W  = 2;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic          fin_valid;
    logic          fin_ready;
    logic [FW-1:0] features_top;
    logic          err_short;
    logic          err_long;
    logic [15:0]   frame_count;

    feature_framer #(
        .NUM_CHANNEL  (N),
        .CHANNEL_WIDTH(W),
        .CNT_WIDTH    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .fin_valid   (fin_valid),
        .fin_ready   (fin_ready),
        .features_top(features_top),
        .err_short   (err_short),
        .err_long    (err_long),
        .frame_count (frame_count)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int mode;
        bit deliver;
        bit short_err;
        bit long_err;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int fails  = 0;

    // reference model state
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] cur_frame;
    int            cur_len;
    int            exp_short_n;
    int            exp_long_n;
    int            exp_frames_n;
    int            short_seen;
    int            long_seen;
    logic [15:0]   xfer_model;
    bit            hold_prev;
    logic [FW-1:0] prev_feat;
    bit            prev_fv;
    int            rise_q[$];
    int            sready_low;
    int            cyc;
    int            fin_mode;

    function automatic void check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void check_wide(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame-level observer: classifies sensor frames, scores every core transfer
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                exp_q.delete();
                cur_len      = 0;
                cur_frame    = '0;
                xfer_model   = '0;
                hold_prev    = 1'b0;
                prev_fv      = 1'b0;
                exp_short_n  = 0;
                exp_long_n   = 0;
                exp_frames_n = 0;
                short_seen   = 0;
                long_seen    = 0;
            end else begin
                if (err_short) short_seen++;
                if (err_long)  long_seen++;
                if (!s_ready)  sready_low++;
                check_val("frame_count", frame_count, xfer_model);
                if (hold_prev) begin
                    check_val("held fin_valid", fin_valid, 1);
                    check_wide("held features_top", features_top, prev_feat);
                end
                if (fin_valid && !prev_fv) rise_q.push_back(cyc);
                if (fin_valid && fin_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpected frame: got fin transfer, expected none pending");
                    end else begin
                        check_wide("frame data", features_top, exp_q.pop_front());
                    end
                    xfer_model++;
                end
                hold_prev = fin_valid && !fin_ready;
                prev_feat = features_top;
                prev_fv   = fin_valid && !fin_ready;
                if (s_valid && s_ready) begin
                    if (cur_len < N) cur_frame[(N - cur_len) * W - 1 -: W] = s_data;
                    cur_len++;
                    if (s_last) begin
                        if (cur_len == N) begin
                            exp_q.push_back(cur_frame);
                            exp_frames_n++;
                        end else if (cur_len < N) begin
                            exp_short_n++;
                        end else begin
                            exp_long_n++;
                        end
                        cur_len   = 0;
                        cur_frame = '0;
                    end
                end
            end
        end
    endtask

    // Core-side ready generator: 0 stall, 1 always ready, 2 random, 3 manual
    task automatic fin_driver();
        forever begin
            @(posedge clk);
            #2;
            case (fin_mode)
                0:       fin_ready = 1'b0;
                1:       fin_ready = 1'b1;
                2:       fin_ready = 1'($urandom_range(1));
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic send_frame(input int len, input int gap_pct, input bit ramp, input bit with_last);
        int k     = 0;
        int guard = 0;
        bit acc;
        while (k < len && guard < 2000) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = ramp ? W'(k % 4) : W'($urandom);
                s_last  = with_last && (k == len - 1);
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            step();
            if (acc) k++;
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_val("send_frame beats accepted", k, len);
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || fin_valid) && g < 2000) begin
            step();
            g++;
        end
        step();
        step();
        check_val(name, (g < 2000), 1);
    endtask

    // Directed, table-driven and randomized stimulus
    initial begin
        int b_short;
        int b_long;
        int b_x;
        int kind;
        int len;

        vecs[0] = '{214, 1, 1, 0, 0};
        vecs[1] = '{100, 1, 0, 1, 0};
        vecs[2] = '{214, 1, 1, 0, 0};
        vecs[3] = '{300, 1, 0, 0, 1};
        vecs[4] = '{1,   1, 0, 1, 0};
        vecs[5] = '{213, 1, 0, 1, 0};
        vecs[6] = '{215, 1, 0, 0, 1};
        vecs[7] = '{214, 2, 1, 0, 0};

        fin_mode   = 1;
        fin_ready  = 1'b0;
        sready_low = 0;
        cyc        = 0;
        fork
            monitor_loop();
            fin_driver();
        join_none

        // reset values
        do_reset();
        check_val("reset fin_valid", fin_valid, 0);
        check_val("reset s_ready", s_ready, 1);
        check_wide("reset features_top", features_top, '0);
        check_val("reset err_short", err_short, 0);
        check_val("reset err_long", err_long, 0);
        check_val("reset frame_count", frame_count, 0);

        // ramp frame
        $display("[TB] ramp frame");
        send_frame(N, 0, 1, 1);
        check_val("ramp fin_valid latency", fin_valid, 1);
        check_val("ramp channel0 msbs", features_top[FW-1 -: 2], 0);
        check_val("ramp channel213 lsbs", features_top[1:0], 1);
        step();
        check_val("ramp fin_valid one cycle", fin_valid, 0);
        check_val("ramp frame_count", frame_count, 1);

        // back-to-back frames
        $display("[TB] back-to-back");
        do_reset();
        rise_q.delete();
        sready_low = 0;
        for (int i = 0; i < 3; i++) send_frame(N, 0, 0, 1);
        drain("b2b drain");
        check_val("b2b s_ready low cycles", sready_low, 0);
        check_val("b2b fin_valid pulses", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            check_val("b2b spacing 1", rise_q[1] - rise_q[0], N);
            check_val("b2b spacing 2", rise_q[2] - rise_q[1], N);
        end
        check_val("b2b frame_count", frame_count, 3);

        // backpressure
        $display("[TB] backpressure");
        do_reset();
        fin_mode = 0;
        send_frame(N, 0, 0, 1);
        send_frame(N, 0, 0, 1);
        check_val("bp s_ready after 2nd last", s_ready, 0);
        check_val("bp fin_valid", fin_valid, 1);
        check_val("bp frames pending", exp_q.size(), 2);
        if (exp_q.size() > 0) check_wide("bp first frame shown", features_top, exp_q[0]);
        repeat (3) step();
        check_val("bp s_ready still low", s_ready, 0);
        fin_mode  = 3;
        fin_ready = 1'b1;
        step();
        fin_ready = 1'b0;
        check_val("bp fin_valid after swap", fin_valid, 1);
        check_val("bp s_ready after swap", s_ready, 1);
        if (exp_q.size() > 0) check_wide("bp second frame shown", features_top, exp_q[0]);
        step();
        check_val("bp second frame held", fin_valid, 1);
        fin_mode = 1;
        drain("bp drain");
        check_val("bp frame_count", frame_count, 2);

        // table of frame shapes
        $display("[TB] frame shape table");
        for (int i = 0; i < 8; i++) begin
            b_short  = short_seen;
            b_long   = long_seen;
            b_x      = int'(xfer_model);
            fin_mode = vecs[i].mode;
            send_frame(vecs[i].len, 0, 0, 1);
            check_val($sformatf("vec%0d err_short pulse", i), err_short, vecs[i].short_err);
            check_val($sformatf("vec%0d err_long pulse", i), err_long, vecs[i].long_err);
            check_val($sformatf("vec%0d fin_valid", i), fin_valid, vecs[i].deliver);
            step();
            check_val($sformatf("vec%0d err_short clear", i), err_short, 0);
            check_val($sformatf("vec%0d err_long clear", i), err_long, 0);
            fin_mode = 1;
            drain($sformatf("vec%0d drain", i));
            check_val($sformatf("vec%0d short count", i), short_seen - b_short, vecs[i].short_err);
            check_val($sformatf("vec%0d long count", i), long_seen - b_long, vecs[i].long_err);
            check_val($sformatf("vec%0d delivered", i), int'(xfer_model) - b_x, vecs[i].deliver);
        end

        // reset mid-frame with a frame pending
        $display("[TB] reset mid-frame");
        fin_mode = 0;
        send_frame(N, 0, 0, 1);
        send_frame(51, 0, 0, 0);
        check_val("mid pending fin_valid", fin_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid async fin_valid", fin_valid, 0);
        check_val("mid async frame_count", frame_count, 0);
        check_wide("mid async features_top", features_top, '0);
        check_val("mid async err_short", err_short, 0);
        step();
        rst      = 1'b1;
        fin_mode = 1;
        step();
        check_val("mid s_ready after reset", s_ready, 1);
        send_frame(N, 0, 0, 1);
        drain("mid drain");
        check_val("mid frame_count", frame_count, 1);
        check_val("mid no error pulses", short_seen + long_seen, 0);

        // randomized traffic
        $display("[TB] random traffic");
        do_reset();
        fin_mode = 2;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(9);
            if (kind < 6)      len = N;
            else if (kind < 8) len = $urandom_range(N - 1, 1);
            else               len = $urandom_range(N + 40, N + 1);
            send_frame(len, 20, 0, 1);
        end
        fin_mode = 1;
        drain("random drain");
        check_val("random short count", short_seen, exp_short_n);
        check_val("random long count", long_seen, exp_long_n);
        check_val("random delivered", int'(xfer_model), exp_frames_n);
        check_val("random frame_count", frame_count, 16'(exp_frames_n));
        check_val("random queue empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
